mem_sram_ctrl: RTL and testbench
================================

// Module: mem_sram_ctrl
// PURPOSE
//  Sequences MEM-stage data-memory accesses onto an external 16-bit asynchronous SRAM.
//  Each 32-bit load/store becomes two halfword accesses, each stretched to WAIT_CYCLES.
//  Sits between the MEM stage (ALU result, store data, read/write enables) and the SRAM pins.
//  'ready' low is the pipeline freeze: while low, the PC and all pipeline registers hold.
// PARAMETERS
//  ADDR_W       18  SRAM halfword address width; word index = addr[ADDR_W:2]
//  WAIT_CYCLES  5   cycles per halfword access; minimum 2
// PORTS
//  clk          in   1        clock, rising edge
//  rst          in   1        reset, asynchronous, active-high
//  mem_r_en     in   1        load request; held stable while ready=0
//  mem_w_en     in   1        store request; held stable while ready=0
//  addr         in   32       byte address from ALU; addr[1:0] ignored
//  wr_data      in   32       store data
//  rd_data      out  32       load data; registered, holds the last completed load
//  ready        out  1        1 = MEM stage may advance this cycle
//  sram_addr    out  ADDR_W   {addr[ADDR_W:2], half}; half=0 selects the low halfword
//  sram_dq_out  out  16       write data to the SRAM pins
//  sram_dq_oe   out  1        1 = drive sram_dq_out onto the SRAM bus
//  sram_dq_in   in   16       read data from the SRAM bus
//  sram_ce_n    out  1        chip enable, active-low
//  sram_oe_n    out  1        output enable, active-low
//  sram_we_n    out  1        write enable, active-low
// BEHAVIOUR
//  Registers: state, cnt [clog2(WAIT_CYCLES)-1:0], rd_data. SRAM controls decode combinationally from state/cnt.
//  States:
//   IDLE   ready = ~(mem_r_en|mem_w_en); cnt=0.
//          mem_r_en -> RD_LO. Else mem_w_en -> WR_LO.
//   RD_LO / RD_HI
//          ce_n=0, oe_n=0, we_n=1, dq_oe=0.
//          On cnt==WAIT_CYCLES-1: capture sram_dq_in into rd_data[15:0] (LO) or [31:16] (HI).
//          Then clear cnt and move on: RD_LO -> RD_HI, RD_HI -> DONE.
//   WR_LO / WR_HI
//          ce_n=0, oe_n=1, dq_oe=1; dq_out = wr_data[15:0] (LO) or wr_data[31:16] (HI).
//          we_n=0 for cnt 0..WAIT_CYCLES-2; we_n=1 at the last cnt (address/data hold).
//          Then clear cnt and move on: WR_LO -> WR_HI, WR_HI -> DONE.
//   DONE   ready=1 for exactly one cycle; SRAM idle; -> IDLE unconditionally.
//          The request still on the inputs is the finished one and is not re-issued.
//  Outside all access states: ce_n=oe_n=we_n=1, dq_oe=0, dq_out=0, sram_addr=0.
//  Latency: request seen in IDLE at cycle 0 -> ready low for cycles 0..2*WAIT_CYCLES.
//   ready high at cycle 2*WAIT_CYCLES+1 (cycle 11 for the default).
//  Both enables high: treated as a load; no SRAM write occurs.
//  Back-to-back accesses: ready is high only in DONE, then low again from IDLE for the next request.
//  rd_data updates only on load halfword captures; stores leave it unchanged.
//  Reset, including mid-access: state=IDLE, cnt=0, rd_data=0, all SRAM strobes inactive immediately.
//   ready = ~(mem_r_en|mem_w_en) while in reset.
//   An interrupted store may leave its halfword partially written; no retry.
// TESTING
//  T1 Reset, no requests -> ready=1, ce_n/oe_n/we_n=1, dq_oe=0, rd_data=0 for 20 cycles.
//  T2 Load, addr=0x10, SRAM[8]=0x1234, SRAM[9]=0xABCD.
//     -> sram_addr=8 for cycles 1-5, then 9 for cycles 6-10; ready=1 at cycle 11 only; rd_data=0xABCD1234.
//  T3 Store, addr=0x20, wr_data=0xDEADBEEF.
//     -> SRAM[0x10]=0xBEEF, SRAM[0x11]=0xDEAD; we_n low 4 cycles per halfword; rd_data unchanged.
//  T4 Store then load to the same word, back to back.
//     -> ready high exactly 1 cycle between the two accesses; load returns the stored word.
//  T5 Reset pulse during RD_HI -> strobes go inactive asynchronously, rd_data=0; after release ready=1.
//  T6 mem_r_en=mem_w_en=1 at addr 0x10 -> load completes in 11 cycles; we_n stays 1; SRAM unchanged.

Source files
------------

// File: rtl/mem_sram_ctrl.sv
// Purpose: turns MEM-stage 32-bit loads/stores into two halfword accesses on a 16-bit async SRAM.
// Latency: 2*WAIT_CYCLES+1 cycles from request in IDLE to the single-cycle ready pulse in DONE.
// Backpressure: ready low freezes the pipeline; the request must be held stable until ready is high.
module mem_sram_ctrl #(
    parameter int ADDR_W      = 18,
    parameter int WAIT_CYCLES = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_r_en,
    input  logic              mem_w_en,
    input  logic [31:0]       addr,
    input  logic [31:0]       wr_data,
    output logic [31:0]       rd_data,
    output logic              ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    input  logic [15:0]       sram_dq_in,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        RD_HI = 3'd2,
        WR_LO = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             cnt_last;

    // Only the word index reaches the SRAM; byte offset and upper address bits are dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, addr[31:ADDR_W+1], addr[1:0]};

    assign cnt_last = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Halfwords are sampled on the last wait cycle, when the SRAM output has settled longest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data <= '0;
        end else if (cnt_last) begin
            if (state == RD_LO) rd_data[15:0]  <= sram_dq_in;
            if (state == RD_HI) rd_data[31:16] <= sram_dq_in;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = '0;
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_ce_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_we_n   = 1'b1;

        case (state)
            IDLE: begin
                ready = ~(mem_r_en | mem_w_en);
                if (mem_r_en)      state_nxt = RD_LO;
                else if (mem_w_en) state_nxt = WR_LO;
            end
            RD_LO, RD_HI: begin
                sram_ce_n = 1'b0;
                sram_oe_n = 1'b0;
                sram_addr = {addr[ADDR_W:2], (state == RD_HI)};
                cnt_nxt   = cnt_last ? '0 : cnt + CNT_W'(1);
                if (cnt_last) state_nxt = (state == RD_LO) ? RD_HI : DONE;
            end
            WR_LO, WR_HI: begin
                sram_ce_n   = 1'b0;
                sram_dq_oe  = 1'b1;
                sram_addr   = {addr[ADDR_W:2], (state == WR_HI)};
                sram_dq_out = (state == WR_HI) ? wr_data[31:16] : wr_data[15:0];
                // we_n rises one cycle early so address and data are held past the write edge.
                sram_we_n   = cnt_last;
                cnt_nxt     = cnt_last ? '0 : cnt + CNT_W'(1);
                if (cnt_last) state_nxt = (state == WR_LO) ? WR_HI : DONE;
            end
            DONE: begin
                ready     = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl against a small behavioural async SRAM.
module tb_mem_sram_ctrl;

    logic        clk;
    logic        rst;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    int n_cmp;
    int n_err;

    logic [15:0] mem [0:1023];

    mem_sram_ctrl #(.ADDR_W(18), .WAIT_CYCLES(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_r_en   (mem_r_en),
        .mem_w_en   (mem_w_en),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n),
        .sram_we_n  (sram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Async SRAM: reads are combinational, writes land on the rising edge of we_n.
    assign sram_dq_in = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr[9:0]] : 16'h0000;
    always @(posedge sram_we_n) begin
        if (!sram_ce_n && sram_dq_oe) mem[sram_addr[9:0]] <= sram_dq_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; drives the request and follows it until ready goes high.
    task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output int we_lo, output logic rdy0, output logic rdy1,
                          output logic [17:0] a1, output logic [17:0] a5,
                          output logic [17:0] a6, output logic [17:0] a10,
                          output logic [15:0] dq2, output logic [15:0] dq7);
        mem_r_en = r;
        mem_w_en = w;
        addr     = a;
        wr_data  = d;
        #1;
        lat = -1; we_lo = 0; rdy0 = ready; rdy1 = 1'bx;
        a1 = '0; a5 = '0; a6 = '0; a10 = '0; dq2 = '0; dq7 = '0;
        for (int c = 1; c < 40; c++) begin
            @(negedge clk);
            if (c == 1)  begin a1 = sram_addr; rdy1 = ready; end
            if (c == 2)  dq2 = sram_dq_out;
            if (c == 5)  a5 = sram_addr;
            if (c == 6)  a6 = sram_addr;
            if (c == 7)  dq7 = sram_dq_out;
            if (c == 10) a10 = sram_addr;
            if (!sram_we_n) we_lo++;
            if (ready) begin
                lat = c;
                break;
            end
        end
    endtask

    int          lat, we_lo;
    logic        rdy0, rdy1;
    logic [17:0] a1, a5, a6, a10;
    logic [15:0] dq2, dq7;

    initial begin
        n_cmp = 0; n_err = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
        mem[8] = 16'h1234;
        mem[9] = 16'hABCD;
        rst = 1'b1; mem_r_en = 1'b0; mem_w_en = 1'b0; addr = '0; wr_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // T1: idle after reset
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("t1_ctrl", {27'd0, ready, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'h1E);
            chk("t1_rd_data", rd_data, 32'h0);
        end

        // T2: load from word 0x10
        access(1'b1, 1'b0, 32'h10, 32'h0, lat, we_lo, rdy0, rdy1, a1, a5, a6, a10, dq2, dq7);
        chk("t2_rdy0", {31'd0, rdy0}, 32'h0);
        chk("t2_lat", lat, 32'd11);
        chk("t2_a1", a1, 32'h8);
        chk("t2_a5", a5, 32'h8);
        chk("t2_a6", a6, 32'h9);
        chk("t2_a10", a10, 32'h9);
        chk("t2_we_lo", we_lo, 32'd0);
        chk("t2_rd_data", rd_data, 32'hABCD1234);
        mem_r_en = 1'b0;
        @(negedge clk);
        chk("t2_idle_ready", {31'd0, ready}, 32'h1);
        chk("t2_idle_addr", sram_addr, 32'h0);

        // T3: store to word 0x20
        access(1'b0, 1'b1, 32'h20, 32'hDEADBEEF, lat, we_lo, rdy0, rdy1, a1, a5, a6, a10, dq2, dq7);
        chk("t3_lat", lat, 32'd11);
        chk("t3_we_lo", we_lo, 32'd8);
        chk("t3_a1", a1, 32'h10);
        chk("t3_a6", a6, 32'h11);
        chk("t3_dq_lo", dq2, 32'hBEEF);
        chk("t3_dq_hi", dq7, 32'hDEAD);
        chk("t3_mem_lo", mem[16], 32'hBEEF);
        chk("t3_mem_hi", mem[17], 32'hDEAD);
        chk("t3_rd_data", rd_data, 32'hABCD1234);
        mem_w_en = 1'b0;
        @(negedge clk);
        chk("t3_idle_dq", {15'd0, sram_dq_oe, sram_dq_out}, 32'h0);

        // T4: store then load of word 0x40, back to back
        access(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, lat, we_lo, rdy0, rdy1, a1, a5, a6, a10, dq2, dq7);
        chk("t4_st_lat", lat, 32'd11);
        access(1'b1, 1'b0, 32'h40, 32'h0, lat, we_lo, rdy0, rdy1, a1, a5, a6, a10, dq2, dq7);
        chk("t4_done_ready", {31'd0, rdy0}, 32'h1);
        chk("t4_idle_ready", {31'd0, rdy1}, 32'h0);
        chk("t4_ld_lat", lat, 32'd12);
        chk("t4_ld_we_lo", we_lo, 32'd0);
        chk("t4_rd_data", rd_data, 32'hCAFEF00D);
        mem_r_en = 1'b0;
        @(negedge clk);

        // T5: reset pulse mid-way through RD_HI
        mem_r_en = 1'b1; addr = 32'h10;
        repeat (7) @(negedge clk);
        chk("t5_pre_oe", {31'd0, sram_oe_n}, 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("t5_rst_strobes", {28'd0, sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 32'hE);
        chk("t5_rst_rd_data", rd_data, 32'h0);
        chk("t5_rst_ready_req", {31'd0, ready}, 32'h0);
        mem_r_en = 1'b0;
        #1;
        chk("t5_rst_ready_idle", {31'd0, ready}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("t5_post_ready", {31'd0, ready}, 32'h1);
        chk("t5_post_ce", {31'd0, sram_ce_n}, 32'h1);

        // T6: both enables high behaves as a load
        access(1'b1, 1'b1, 32'h10, 32'h55555555, lat, we_lo, rdy0, rdy1, a1, a5, a6, a10, dq2, dq7);
        chk("t6_lat", lat, 32'd11);
        chk("t6_we_lo", we_lo, 32'd0);
        chk("t6_rd_data", rd_data, 32'hABCD1234);
        chk("t6_mem_lo", mem[8], 32'h1234);
        chk("t6_mem_hi", mem[9], 32'hABCD);
        mem_r_en = 1'b0; mem_w_en = 1'b0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
